// File: rtl/pxs_vga_timing_gen_if.sv
// Stream bundle for the iPxs source stage: advance enable in, 23-bit VGA stream
// and optional frame pulse out.
interface pxs_vga_timing_gen_if;
  logic        en;
  logic [22:0] vga_str;
  logic        frame;

  // The generator is the stream master; downstream pixel stages are slaves.
  modport master (input en, output vga_str, output frame);
  modport slave  (output en, input vga_str, input frame);
endinterface

// File: rtl/pxs_vga_timing_gen.sv
// iPxs stream source: free-running H/V counters with a registered 23-bit VGA stream.
// Optional macro PXS_FRAME_PULSE_EN adds frame_o, high alongside the (0,0) pixel.
module pxs_vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        px_clk,
  input  logic        rst,
  input  logic        en,
  output logic [22:0] VGAStr_o
`ifdef PXS_FRAME_PULSE_EN
  ,
  output logic        frame_o
`endif
);

  localparam int H_TOTAL_I = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL_I = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 11-bit compare constants so a total of exactly 1024 still fits.
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_S = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_E = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL_I - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_S = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_E = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL_I - 1);
  localparam logic [10:0] V_TOTAL  = 11'(V_TOTAL_I);

  localparam logic [22:0] IDLE_STR = {20'd0, ~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [9:0]  hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [22:0] str_q, str_d;
  logic [10:0] h_ext, v_ext;
  logic        h_in_sync, v_in_sync, active;

  always_comb begin
    h_ext     = {1'b0, hcnt_q};
    v_ext     = {1'b0, vcnt_q};
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    str_d     = str_q;
    active    = (h_ext < H_ACT) && (v_ext < V_ACT);
    h_in_sync = (h_ext >= H_SYNC_S) && (h_ext < H_SYNC_E);
    v_in_sync = (v_ext >= V_SYNC_S) && (v_ext < V_SYNC_E);

    if (en) begin
      str_d = {hcnt_q, vcnt_q,
               h_in_sync ? SYNC_POL : ~SYNC_POL,
               v_in_sync ? SYNC_POL : ~SYNC_POL,
               active};
      // ">=" rather than "==" so a corrupted counter recovers on the next enabled edge.
      if (h_ext >= H_LAST) begin
        hcnt_d = '0;
        if (v_ext >= V_LAST) vcnt_d = '0;
        else                 vcnt_d = vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
        if (v_ext >= V_TOTAL) vcnt_d = '0;
      end
    end
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      str_q  <= IDLE_STR;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      str_q  <= str_d;
    end
  end

  assign VGAStr_o = str_q;

`ifdef PXS_FRAME_PULSE_EN
  logic frame_q, frame_d;

  // Registered from the same counter state as the stream so it lines up with (0,0).
  always_comb begin
    frame_d = frame_q;
    if (en) frame_d = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
  end

  always_ff @(posedge px_clk) begin
    if (rst) frame_q <= 1'b0;
    else     frame_q <= frame_d;
  end

  assign frame_o = frame_q;
`endif

endmodule
